// File: rtl/bsg_prbs_xnor_check.sv
// ---------------------------------------------------------------------------
// bsg_prbs_xnor_check
//
// Receive-side checker for the 16-bit XNOR-feedback PRBS link-test stream.
// An internal LFSR is seeded from the incoming data. Once sync_words_p
// consecutive words match the prediction, the checker declares lock. While
// locked, the prediction free-runs. Every mismatching word is then counted,
// pulsed and captured as a bitwise match mask ~(data ^ expected).
// loss_thresh_p consecutive mismatches drop lock, and the checker reseeds.
//
// Ports
//   clk_i        : sole clock, rising edge
//   reset_i      : synchronous active-high reset
//   en_i         : checking enable; low forces the seed state
//   clear_i      : clears err_count_o and mask_o
//   v_i/data_i   : received word and its valid
//   ready_o      : word accepted when v_i & ready_o
//   locked_o     : checker is locked to the stream
//   error_v_o    : one-cycle pulse per counted mismatch
//   mask_o       : match mask of the most recent counted mismatch
//   err_count_o  : saturating count of counted mismatches
// ---------------------------------------------------------------------------
module bsg_prbs_xnor_check #(
  parameter int sync_words_p      = 4,
  parameter int loss_thresh_p     = 3,
  parameter int err_count_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic                         clear_i,
  input  logic                         v_i,
  input  logic [15:0]                  data_i,
  output logic                         ready_o,
  output logic                         locked_o,
  output logic                         error_v_o,
  output logic [15:0]                  mask_o,
  output logic [err_count_width_p-1:0] err_count_o
);

  localparam logic [1:0] eSeed   = 2'd0;
  localparam logic [1:0] eSync   = 2'd1;
  localparam logic [1:0] eLocked = 2'd2;

  // Each counter only has to reach its threshold minus one. The transition
  // out of the state is taken on the word that would make it equal the
  // threshold.
  localparam int sync_w_lp = (sync_words_p  > 1) ? $clog2(sync_words_p)  : 1;
  localparam int miss_w_lp = (loss_thresh_p > 1) ? $clog2(loss_thresh_p) : 1;
  localparam logic [sync_w_lp-1:0] sync_last_lp = sync_w_lp'(sync_words_p - 1);
  localparam logic [miss_w_lp-1:0] miss_last_lp = miss_w_lp'(loss_thresh_p - 1);

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
  endfunction

  logic [1:0]                   state_q, state_d;
  logic [15:0]                  exp_q, exp_d;
  logic [sync_w_lp-1:0]         sync_cnt_q, sync_cnt_d;
  logic [miss_w_lp-1:0]         miss_cnt_q, miss_cnt_d;
  logic                         ready_q;
  logic                         locked_q;
  logic                         error_v_q, error_v_d;
  logic [15:0]                  mask_q, mask_d;
  logic [err_count_width_p-1:0] err_count_q, err_count_d;

  logic accept;
  logic match;
  logic seed_ok;

  assign accept  = v_i & ready_q;
  assign match   = (data_i == exp_q);
  // All-ones is the XNOR LFSR lock-up state and can never seed a sequence.
  assign seed_ok = (data_i != 16'hFFFF);

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    exp_d       = exp_q;
    sync_cnt_d  = sync_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    error_v_d   = 1'b0;
    mask_d      = mask_q;
    err_count_d = err_count_q;

    // Clear is applied first, so a mismatch in the same cycle counts from 0.
    if (clear_i) begin
      err_count_d = '0;
      mask_d      = '0;
    end

    if (!en_i) begin
      state_d = eSeed;
    end else if (accept) begin
      case (state_q)
        eSeed: begin
          if (seed_ok) begin
            exp_d      = lfsr_next(data_i);
            sync_cnt_d = '0;
            state_d    = eSync;
          end
        end
        eSync: begin
          if (match) begin
            exp_d = lfsr_next(exp_q);
            if (sync_cnt_q == sync_last_lp) begin
              state_d    = eLocked;
              miss_cnt_d = '0;
            end else begin
              sync_cnt_d = sync_cnt_q + 1'b1;
            end
          end else if (seed_ok) begin
            exp_d      = lfsr_next(data_i);
            sync_cnt_d = '0;
          end else begin
            state_d = eSeed;
          end
        end
        eLocked: begin
          exp_d = lfsr_next(exp_q);
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            error_v_d = 1'b1;
            mask_d    = ~(data_i ^ exp_q);
            if (err_count_d != '1) begin
              err_count_d = err_count_d + 1'b1;
            end
            if (miss_cnt_q == miss_last_lp) begin
              state_d = eSeed;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = eSeed;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= eSeed;
      exp_q       <= '0;
      sync_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      ready_q     <= 1'b0;
      locked_q    <= 1'b0;
      error_v_q   <= 1'b0;
      mask_q      <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      sync_cnt_q  <= sync_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      ready_q     <= 1'b1;
      locked_q    <= (state_d == eLocked);
      error_v_q   <= error_v_d;
      mask_q      <= mask_d;
      err_count_q <= err_count_d;
    end
  end

  assign ready_o     = ready_q;
  assign locked_o    = locked_q;
  assign error_v_o   = error_v_q;
  assign mask_o      = mask_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_bsg_prbs_xnor_check.sv
// ---------------------------------------------------------------------------
// tb_bsg_prbs_xnor_check
//
// Directed bench for bsg_prbs_xnor_check with default parameters
// (sync 4, loss 3, 8-bit counter). Inputs change 1 time unit after a rising
// edge, and outputs are sampled at that same point, after the edge has
// registered them.
// ---------------------------------------------------------------------------
module tb_bsg_prbs_xnor_check;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic        clear_i;
  logic        v_i;
  logic [15:0] data_i;
  logic        ready_o;
  logic        locked_o;
  logic        error_v_o;
  logic [15:0] mask_o;
  logic [7:0]  err_count_o;

  int vectors     = 0;
  int miscompares = 0;

  bsg_prbs_xnor_check #(
    .sync_words_p     (4),
    .loss_thresh_p    (3),
    .err_count_width_p(8)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .clear_i    (clear_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .locked_o   (locked_o),
    .error_v_o  (error_v_o),
    .mask_o     (mask_o),
    .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic lk, input logic ev,
                            input logic [15:0] mk, input logic [7:0] cnt);
    check({tag, ".locked"}, {31'd0, locked_o}, {31'd0, lk});
    check({tag, ".error_v"}, {31'd0, error_v_o}, {31'd0, ev});
    check({tag, ".mask"}, {16'd0, mask_o}, {16'd0, mk});
    check({tag, ".count"}, {24'd0, err_count_o}, {24'd0, cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    v_i    = 1'b1;
    data_i = w;
    tick();
    v_i    = 1'b0;
  endtask

  // Seed 0x0001 followed by its four successors; this locks the checker.
  task automatic lock_seq();
    send(16'h0001);
    send(16'h0003);
    send(16'h0007);
    send(16'h000F);
    send(16'h001E);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b1;
    en_i    = 1'b1;
    clear_i = 1'b0;
    v_i     = 1'b0;
    data_i  = '0;
    tick();
    tick();
    check("reset.ready", {31'd0, ready_o}, 32'd0);
    expect_out("reset", 1'b0, 1'b0, 16'h0000, 8'd0);

    // First cycle after release: ready still low, then high.
    reset_i = 1'b0;
    check("release.ready_low", {31'd0, ready_o}, 32'd0);
    tick();
    check("release.ready_high", {31'd0, ready_o}, 32'd1);

    // Lock: seed plus four matches; lock shows right after 0x001E.
    send(16'h0001); expect_out("lock.w0", 1'b0, 1'b0, 16'h0000, 8'd0);
    send(16'h0003); expect_out("lock.w1", 1'b0, 1'b0, 16'h0000, 8'd0);
    send(16'h0007); expect_out("lock.w2", 1'b0, 1'b0, 16'h0000, 8'd0);
    send(16'h000F); expect_out("lock.w3", 1'b0, 1'b0, 16'h0000, 8'd0);
    send(16'h001E); expect_out("lock.w4", 1'b1, 1'b0, 16'h0000, 8'd0);

    // Single bit error: expected 0x003C, then 0x0078 matches.
    send(16'h003D); expect_out("biterr", 1'b1, 1'b1, 16'hFFFE, 8'd1);
    send(16'h0078); expect_out("biterr.next", 1'b1, 1'b0, 16'hFFFE, 8'd1);

    // Lock loss: the expected words are 0x00F0, 0x01E1 and 0x03C3; send 0 three times.
    send(16'h0000); expect_out("loss.1", 1'b1, 1'b1, 16'hFF0F, 8'd2);
    send(16'h0000); expect_out("loss.2", 1'b1, 1'b1, 16'hFE1E, 8'd3);
    send(16'h0000); expect_out("loss.3", 1'b0, 1'b1, 16'hFC3C, 8'd4);
    lock_seq();     expect_out("relock", 1'b1, 1'b0, 16'hFC3C, 8'd4);

    // Enable drop while locked: lock falls, count and mask retained.
    en_i = 1'b0;
    tick();
    expect_out("en_low", 1'b0, 1'b0, 16'hFC3C, 8'd4);
    en_i = 1'b1;

    // 0xFFFF is never a seed: five of them must not lock.
    for (int i = 0; i < 5; i++) send(16'hFFFF);
    expect_out("ffff_seed", 1'b0, 1'b0, 16'hFC3C, 8'd4);

    // Sync mismatch reseeds from 0x1234 silently. The words that follow
    // 0x1234 are 0x2468, 0x48D0, 0x91A0 and 0x2341.
    send(16'h0001);
    send(16'h0003);
    send(16'h1234); expect_out("sync_mis", 1'b0, 1'b0, 16'hFC3C, 8'd4);
    send(16'h2468);
    send(16'h48D0);
    send(16'h91A0); expect_out("resync.3", 1'b0, 1'b0, 16'hFC3C, 8'd4);
    send(16'h2341); expect_out("resync.4", 1'b1, 1'b0, 16'hFC3C, 8'd4);

    // Saturation: leave lock, then 100 rounds of lock plus 3 inverted words.
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    for (int r = 0; r < 100; r++) begin
      lock_seq();
      send(16'hFFC3);
      send(16'hFF87);
      send(16'hFF0F);
    end
    expect_out("saturate", 1'b0, 1'b1, 16'h0000, 8'hFF);

    // A further single bit error while saturated sets the mask; the count holds.
    lock_seq();
    send(16'h003D); expect_out("sat_hold", 1'b1, 1'b1, 16'hFFFE, 8'hFF);

    // clear_i alone.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    expect_out("clear", 1'b1, 1'b0, 16'h0000, 8'd0);

    // clear_i together with a mismatch (expected 0x0078, sent 0x0070).
    clear_i = 1'b1;
    send(16'h0070);
    clear_i = 1'b0;
    expect_out("clear_mis", 1'b1, 1'b1, 16'hFFF7, 8'd1);
    send(16'h00F0); expect_out("post_clear", 1'b1, 1'b0, 16'hFFF7, 8'd1);

    // Reset mid-stream with a word in flight.
    reset_i = 1'b1;
    send(16'h01E1);
    check("midreset.ready", {31'd0, ready_o}, 32'd0);
    expect_out("midreset", 1'b0, 1'b0, 16'h0000, 8'd0);
    reset_i = 1'b0;
    // The word offered while ready is low must be dropped, so 0x0003 becomes the seed.
    send(16'h0001);
    check("midreset.ready_high", {31'd0, ready_o}, 32'd1);
    send(16'h0003);
    send(16'h0007);
    send(16'h000F);
    send(16'h001E); expect_out("ready_gate", 1'b0, 1'b0, 16'h0000, 8'd0);
    send(16'h003C); expect_out("ready_gate.lock", 1'b1, 1'b0, 16'h0000, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_prbs_xnor_check.md
# bsg_prbs_xnor_check

Receive-side checker for the 16-bit XNOR-feedback PRBS link-test stream. It self-synchronises its expected-pattern LFSR to the incoming words and flags bit mismatches. Its bitwise match mask is the XNOR of the received and expected words. It sits at the sink end of a link under test, behind a valid/ready channel, and exposes lock status, error pulses, a saturating error count and the last mismatch mask.

## Interface
- sync_words_p, default 4: consecutive matching words after the seed that are required to declare lock (≥1).
- loss_thresh_p, default 3: consecutive mismatching words in lock that force resync (≥1).
- err_count_width_p, default 8: width of the saturating error counter.

- clk_i  in  1  sole clock; everything is on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- en_i  in  1  checking enable; low forces eSeed.
- clear_i  in  1  clears err_count_o and mask_o.
- v_i  in  1  data_i valid.
- data_i  in  16  received PRBS word.
- ready_o  out  1  checker can accept; a word is accepted when v_i & ready_o.
- locked_o  out  1  checker is in eLocked.
- error_v_o  out  1  one-cycle pulse per counted mismatch.
- mask_o  out  16  ~(data ^ expected) for the most recent counted mismatch.
- err_count_o  out  err_count_width_p  saturating count of counted mismatches.

## Operation
- LFSR step: next(s) = {s[14:0], ~(s[15]^s[14]^s[12]^s[3])}. 16'hFFFF is the lock-up state and is never used as a seed.
- The expected register exp_r holds the word predicted for the next accepted word.
- FSM states are eSeed, eSync and eLocked. Only accepted words advance the FSM or exp_r.
- eSeed, on an accepted word w:
  - w == 16'hFFFF: ignore it and stay in eSeed.
  - Otherwise: exp_r <= next(w), sync_cnt <= 0, go to eSync.
- eSync, on an accepted word w:
  - w == exp_r: exp_r <= next(exp_r) and sync_cnt increments. When it reaches sync_words_p, go to eLocked with miss_cnt <= 0.
  - Mismatch: reseed from w, using the same rule as eSeed. A w of 16'hFFFF goes to eSeed. Mismatches in eSync are never counted.
- eLocked, on an accepted word w:
  - exp_r <= next(exp_r) unconditionally; the expected sequence free-runs.
  - Match: miss_cnt <= 0.
  - Mismatch:
    - error_v_o pulses.
    - mask_o <= ~(w ^ exp_r).
    - err_count_o increments, saturating at all-ones.
    - miss_cnt increments. When it reaches loss_thresh_p, go to eSeed.
- en_i low in any state: go to eSeed next cycle, and accepted words are ignored. err_count_o and mask_o are retained.
- clear_i: err_count_o <= 0 and mask_o <= 0.
  - If a counted mismatch arrives in the same cycle, err_count_o <= 1 and mask_o takes the new mask.
  - Saturation then applies from that value.
- ready_o is low in the first cycle after reset deasserts and high thereafter. Backpressure is otherwise never applied.

## Timing
- All outputs are registered.
- Reset values: ready_o=0, locked_o=0, error_v_o=0, mask_o=16'h0000, err_count_o=0. The FSM is in eSeed, with exp_r=0, sync_cnt=0, miss_cnt=0.
- Reset asserted mid-stream returns everything to these values at that edge. The word accepted in that cycle is discarded.
- locked_o rises 1 cycle after the accept edge of the sync_words_p-th matching word. It falls 1 cycle after the accept edge of the loss_thresh_p-th consecutive mismatch, or after the edge sampling en_i=0.
- error_v_o is high exactly 1 cycle after the mismatching word's accept edge. mask_o and err_count_o update on that same edge. Back-to-back mismatches give back-to-back pulses.
- The mismatch that causes loss of lock is counted and pulsed. The following word is treated as a seed.
- Throughput: 1 word per cycle once ready_o is high.

## Test plan
- Lock, sync_words_p=4: after reset, send 0x0001, 0x0003, 0x0007, 0x000F, 0x001E back-to-back.
  - Required: locked_o=1 one cycle after 0x001E is accepted; error_v_o never pulses.
- Single bit error: from the locked state above, send 0x003D (expected 0x003C), then 0x0078.
  - Required: one error_v_o pulse; mask_o=0xFFFE; err_count_o=1; locked_o stays 1.
  - The 0x0078 word produces no error.
- Lock loss, loss_thresh_p=3: while locked, send 3 consecutive wrong words.
  - Required: 3 pulses and err_count_o=3; locked_o=0 one cycle after the third word.
  - A new seed 0x0001 followed by 4 correct words relocks.
- Seed and sync rules:
  - Seed 0xFFFF: stays in eSeed; locked_o stays 0.
  - In eSync, a mismatch such as 0x0001, 0x0003, 0x1234: no error pulse; the block reseeds from 0x1234.
- Saturation and clear, err_count_width_p=8: force 300 mismatches in lock (relocking as needed).
  - Required: err_count_o=0xFF.
  - clear_i alone gives 0.
  - clear_i in the same cycle as a mismatch gives err_count_o=1.
- Enable and reset mid-stream:
  - Drop en_i while locked: locked_o=0 next cycle; err_count_o is retained.
  - Assert reset_i mid-stream: all outputs return to reset values, and ready_o stays 0 for one cycle after release.
